// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: walks the three RGB PWM duty channels around a six-phase
// hue wheel (R->Y->G->C->B->M->R) and delivers each new duty triple over a
// valid/ready handshake, stalling the ramp while a triple is still pending.
// Optional feature macro: RATE_CFG_EN (adds the step_cfg run-time step length).
module rgb_hue_sequencer #(
    parameter int unsigned  PWM_INTERVAL = 1200,
    parameter int unsigned  STEP_CYCLES  = 1666,
    localparam int unsigned DW           = $clog2(PWM_INTERVAL + 1),
    localparam int unsigned SW           = $clog2(STEP_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
`ifdef RATE_CFG_EN
    input  logic [SW-1:0] step_cfg,
`endif
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic          duty_valid,
    input  logic          duty_ready,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          cycle_done
);

    localparam logic [DW-1:0] Full     = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] RampLast = DW'(PWM_INTERVAL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_t;

    state_t        state_q;
    logic [DW-1:0] ramp_q;
    logic [SW-1:0] step_cnt_q;
    logic [SW-1:0] step_len;
    logic          step_term;
    logic          can_emit;

`ifdef RATE_CFG_EN
    logic [SW-1:0] step_len_q;
    logic [SW-1:0] cfg_len;

    // A configured length of zero behaves as a one-clock step.
    assign cfg_len  = (step_cfg == '0) ? SW'(1) : step_cfg;
    assign step_len = step_len_q;
`else
    assign step_len = SW'(STEP_CYCLES);
`endif

    assign step_term = (step_cnt_q == step_len - SW'(1));
    // A ramp step may only emit once the previous triple is gone or leaving.
    assign can_emit  = !duty_valid || duty_ready;
    assign busy      = (state_q != StIdle);

    // Hue wheel: {r, g, b} for a given phase and ramp position.
    function automatic logic [3*DW-1:0] duty_map(input logic [2:0] ph, input logic [DW-1:0] rp);
        logic [DW-1:0] up;
        logic [DW-1:0] dn;
        up = rp;
        dn = Full - rp;
        case (ph)
            3'd0:    duty_map = {Full, up, DW'(0)};
            3'd1:    duty_map = {dn, Full, DW'(0)};
            3'd2:    duty_map = {DW'(0), Full, up};
            3'd3:    duty_map = {DW'(0), dn, Full};
            3'd4:    duty_map = {up, DW'(0), Full};
            3'd5:    duty_map = {Full, DW'(0), dn};
            default: duty_map = '0;
        endcase
    endfunction

    // Sequencer FSM with registered duty, handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase      <= 3'd0;
            ramp_q     <= '0;
            step_cnt_q <= '0;
            duty_r     <= '0;
            duty_g     <= '0;
            duty_b     <= '0;
            duty_valid <= 1'b0;
            cycle_done <= 1'b0;
`ifdef RATE_CFG_EN
            step_len_q <= SW'(STEP_CYCLES);
`endif
        end else begin
            cycle_done <= 1'b0;
            if (duty_valid && duty_ready) begin
                duty_valid <= 1'b0;
            end

            if (stop && state_q != StIdle) begin
                state_q    <= StIdle;
                phase      <= 3'd0;
                ramp_q     <= '0;
                step_cnt_q <= '0;
                {duty_r, duty_g, duty_b} <= '0;
                duty_valid <= 1'b1;
            end else if (start && !stop) begin
                state_q    <= StRun;
                phase      <= 3'd0;
                ramp_q     <= '0;
                step_cnt_q <= '0;
                {duty_r, duty_g, duty_b} <= duty_map(3'd0, '0);
                duty_valid <= 1'b1;
`ifdef RATE_CFG_EN
                step_len_q <= cfg_len;
`endif
            end else if (state_q != StIdle) begin
                state_q <= hold ? StHold : StRun;
                if (!hold) begin
                    if (!step_term) begin
                        step_cnt_q <= step_cnt_q + SW'(1);
                    end else if (can_emit) begin
                        // Terminal count with a free slot: advance the ramp and emit.
                        step_cnt_q <= '0;
                        duty_valid <= 1'b1;
                        if (ramp_q == RampLast) begin
                            ramp_q     <= '0;
                            phase      <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                            cycle_done <= (phase == 3'd5);
                            {duty_r, duty_g, duty_b} <=
                                duty_map((phase == 3'd5) ? 3'd0 : phase + 3'd1, '0);
`ifdef RATE_CFG_EN
                            step_len_q <= cfg_len;
`endif
                        end else begin
                            ramp_q <= ramp_q + DW'(1);
                            {duty_r, duty_g, duty_b} <= duty_map(phase, ramp_q + DW'(1));
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Self-checking bench for rgb_hue_sequencer: directed cycle-length, hold and stop
// scenarios plus randomized control/backpressure, all compared every clock against
// a position-based model of the hue wheel.
module tb_rgb_hue_sequencer;

    localparam int F   = 4;
    localparam int S   = 3;
    localparam int DW  = 3;
    localparam int CYC = 6 * F * S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hold = 1'b0;
    logic          duty_ready = 1'b0;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic          duty_valid, busy, cycle_done;
    logic [2:0]    phase;
`ifdef RATE_CFG_EN
    logic [1:0]    step_cfg = 2'd3;
`endif

    int checks = 0;
    int errors = 0;

    // Model: m_pos = clocks of progress into the 72-clock wheel.
    bit m_act, m_valid, m_done;
    int m_pos, m_r, m_g, m_b;

    rgb_hue_sequencer #(.PWM_INTERVAL(F), .STEP_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
`ifdef RATE_CFG_EN
        .step_cfg(step_cfg),
`endif
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .phase(phase), .busy(busy), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hue(input int ph, input int rp);
        int up, dn;
        up = rp;
        dn = F - rp;
        case (ph)
            0: begin m_r = F;  m_g = up; m_b = 0;  end
            1: begin m_r = dn; m_g = F;  m_b = 0;  end
            2: begin m_r = 0;  m_g = F;  m_b = up; end
            3: begin m_r = 0;  m_g = dn; m_b = F;  end
            4: begin m_r = up; m_g = 0;  m_b = F;  end
            default: begin m_r = F; m_g = 0; m_b = dn; end
        endcase
    endtask

    task automatic model_reset();
        m_act = 0; m_valid = 0; m_done = 0; m_pos = 0;
        m_r = 0; m_g = 0; m_b = 0;
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_next();
        bit acc, emit;
        acc = m_valid && duty_ready;
        emit = 0;
        m_done = 0;
        if (stop && m_act) begin
            m_act = 0; m_pos = 0; m_r = 0; m_g = 0; m_b = 0; m_valid = 1;
        end else if (start && !stop) begin
            m_act = 1; m_pos = 0; hue(0, 0); m_valid = 1;
        end else begin
            if (m_act && !hold) begin
                if (m_pos % S != S - 1) begin
                    m_pos++;
                end else if (!m_valid || duty_ready) begin
                    m_pos = (m_pos + 1) % CYC;
                    hue((m_pos / S) / F, (m_pos / S) % F);
                    m_done = (m_pos == 0);
                    emit = 1;
                end
            end
            if (emit) m_valid = 1;
            else if (acc) m_valid = 0;
        end
    endtask

    task automatic check_all();
        check("busy", 32'(busy), 32'(m_act));
        check("phase", 32'(phase), 32'((m_pos / S) / F));
        check("valid", 32'(duty_valid), 32'(m_valid));
        check("duty_r", 32'(duty_r), 32'(m_r));
        check("duty_g", 32'(duty_g), 32'(m_g));
        check("duty_b", 32'(duty_b), 32'(m_b));
        check("cycle_done", 32'(cycle_done), 32'(m_done));
    endtask

    // One clock: compare on the falling edge, then drive the next inputs.
    task automatic cycle(input bit s, input bit p, input bit h, input bit r);
        @(negedge clk);
        check_all();
        start = s; stop = p; hold = h; duty_ready = r;
        model_next();
    endtask

    task automatic reset_now();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 0; stop = 0; hold = 0; duty_ready = 0;
        #1;
        model_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(duty_valid), 0);
        check("rst_duty", 32'({duty_r, duty_g, duty_b}), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_done", 32'(cycle_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Restart and report the clock (relative to the start edge) of the first wrap pulse.
    task automatic measure(input int hold_from, input int hold_len, output int t);
        bit h;
        t = -1;
        cycle(1, 0, 0, 1);
        for (int k = 1; k <= 300; k++) begin
            h = (k >= hold_from) && (k < hold_from + hold_len);
            cycle(0, 0, h, 1);
            if (cycle_done === 1'b1 && t < 0) t = k - 1;
        end
    endtask

    initial begin
        int t;
        bit h;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running wheel, no backpressure: wrap 72 clocks after start.
        measure(0, 0, t);
        check("cycle_len", 32'(t), 32'(CYC));

        // Hold for 8 clocks inside phase 2 delays the wrap by exactly 8.
        measure(29, 8, t);
        check("cycle_len_hold", 32'(t), 32'(CYC + 8));

        // Stop mid phase 3 with the zero triple left pending.
        cycle(1, 0, 0, 1);
        for (int k = 1; k <= 40; k++) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_valid", 32'(duty_valid), 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Start and stop together in IDLE: stop wins, nothing emitted.
        cycle(1, 1, 0, 1);
        cycle(0, 0, 0, 1);
        check("startstop_busy", 32'(busy), 0);
        check("startstop_valid", 32'(duty_valid), 0);

        // Randomized control and backpressure, with one reset mid-run.
        h = 0;
        for (int i = 0; i < 4000; i++) begin
            bit s, p, r;
            if (i == 2000) reset_now();
            s = m_act ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 39) == 0) h = ~h;
            r = ($urandom_range(0, 3) != 0);
            cycle(s, p, h, r);
        end
        cycle(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
